// File: rtl/spi_seq_pkg.sv
// Shared types and command constants for the SPI sweep sequencer.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RX,
        S_DONE
    } state_e;

    localparam logic [1:0]  CONVERT_OP     = 2'b00;
    localparam logic [15:0] DUMMY_CMD      = 16'hE800;
    localparam int          PIPE_DEPTH_DEF = 2;

endpackage

// File: rtl/spi_seq_ctrl.sv
// Sweep sequencer: issues CONVERT/dummy frames to an SPI engine and
// tags pipelined results with sweep count and channel index.
module spi_seq_ctrl
    import spi_seq_pkg::*;
#(
    parameter int CH_W       = 5,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_trig,
    input  logic            abort_trig,
    input  logic [CH_W-1:0] last_ch,
    input  logic            loop_en,
    output logic            frame_valid,
    output logic [15:0]     frame_data,
    input  logic            frame_ready,
    input  logic            rx_valid,
    input  logic [15:0]     rx_data,
    output logic            out_valid,
    output logic [31:0]     out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int FW = CH_W + 8;

    state_e          state_q, state_d;
    logic [FW-1:0]   f_q, f_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [7:0]      sweep_q, sweep_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;

    logic [FW-1:0]   f_end;
    logic [4:0]      ch;
    logic [15:0]     cmd;

    assign f_end = FW'(last_q) + FW'(PIPE_DEPTH);
    assign ch    = 5'(f_q - FW'(PIPE_DEPTH));
    assign cmd   = (f_q <= FW'(last_q))
                 ? {CONVERT_OP, 1'b0, 5'(f_q), 8'h00}
                 : DUMMY_CMD;

    assign frame_valid = (state_q == S_ISSUE);
    assign frame_data  = frame_valid ? cmd : 16'h0000;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign overflow    = ovf_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        last_d      = last_q;
        sweep_d     = sweep_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_trig && !abort_trig) begin
                    last_d  = last_ch;
                    f_d     = '0;
                    pend_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_trig) begin
                    state_d = S_IDLE;
                end else if (frame_ready) begin
                    state_d = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (abort_trig) begin
                    pend_d = 1'b1;
                end
                if (rx_valid) begin
                    // The first PIPE_DEPTH words belong to no channel of this sweep.
                    if (f_q >= FW'(PIPE_DEPTH)) begin
                        if (out_ready) begin
                            out_valid_d = 1'b1;
                            out_data_d  = {sweep_q, 3'b000, ch, rx_data};
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (pend_q || abort_trig) begin
                        state_d = S_IDLE;
                    end else if (f_q == f_end) begin
                        state_d = S_DONE;
                    end else begin
                        f_d     = f_q + FW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                sweep_d = sweep_q + 8'd1;
                f_d     = '0;
                if (loop_en && !abort_trig) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            f_q         <= '0;
            last_q      <= '0;
            sweep_q     <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            last_q      <= last_d;
            sweep_q     <= sweep_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/spi_seq_ctrl.md
SPI_SEQ_CTRL -- requirements
Module: spi_seq_ctrl

Interface
REQ-001 Parameter CH_W, default 5: channel index width; max 32 channels per sweep.
REQ-002 Parameter PIPE_DEPTH, default 2: sensor result latency in frames.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start_trig  in  1  one-cycle sweep start pulse (ep41trigin[0]).
REQ-006 abort_trig  in  1  one-cycle abort pulse (ep40trigin[0]).
REQ-007 last_ch  in  CH_W  highest channel index to convert (ep05wirein[4:0]).
REQ-008 loop_en  in  1  restart sweeps continuously when high.
REQ-009 frame_valid  out  1  command frame offered to SPI engine.
REQ-010 frame_data  out  16  command word.
REQ-011 frame_ready  in  1  SPI engine accepts frame when high with frame_valid.
REQ-012 rx_valid  in  1  one-cycle pulse: frame's 16-bit MISO word complete.
REQ-013 rx_data  in  16  received word.
REQ-014 out_valid  out  1  one-cycle result pulse to FIFO.
REQ-015 out_data  out  32  {sweep_cnt[7:0], 3'b0, ch[4:0], rx_data[15:0]}.
REQ-016 out_ready  in  1  FIFO not full.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse at sweep end.
REQ-019 overflow  out  1  sticky: result dropped because out_ready was low.

Function
REQ-020 States: IDLE, ISSUE, WAIT_RX, DONE.
REQ-021 Sweep = last_ch+1+PIPE_DEPTH frames; frame index f counts 0 to last_ch+PIPE_DEPTH.
REQ-022 Frame f <= last_ch: frame_data = CONVERT(f) = {2'b00, 1'b0, f[4:0], 8'h00}; f > last_ch: frame_data = DUMMY_CMD = 16'hE800.
REQ-023 IDLE: start_trig -> latch last_ch, f=0, enter ISSUE next cycle; last_ch changes mid-sweep are ignored.
REQ-024 ISSUE: frame_valid=1, frame_data stable until the frame_ready handshake; on handshake -> WAIT_RX.
REQ-025 WAIT_RX: frame_valid=0; on rx_valid: if f >= PIPE_DEPTH, out_valid=1 on the next cycle with ch=f-PIPE_DEPTH; rx words for f < PIPE_DEPTH are discarded.
REQ-026 After rx_valid in WAIT_RX: if f = last_ch+PIPE_DEPTH -> DONE, else f++ -> ISSUE.
REQ-027 Results are never stalled: out_ready=0 when a result is due -> out_valid=0, word dropped, overflow=1 until reset.
REQ-028 DONE: done=1 for one cycle; sweep_cnt increments modulo 256; loop_en=1 -> f=0, ISSUE; else IDLE.
REQ-029 start_trig while busy is ignored.
REQ-030 abort_trig in ISSUE before handshake -> IDLE next cycle, no done pulse.
REQ-031 abort_trig in WAIT_RX -> set abort_pending; the in-flight rx completes (result still emitted), then IDLE, no done pulse.
REQ-032 abort_trig in DONE -> IDLE regardless of loop_en; done pulse still issued.
REQ-033 start_trig and abort_trig in the same cycle in IDLE: abort wins, remain IDLE.
REQ-034 rx_valid outside WAIT_RX is ignored.
REQ-035 last_ch=0 is legal: 3 frames (CONVERT(0), 2 dummies), one result.

Reset
REQ-036 reset low: state=IDLE, f=0, sweep_cnt=0, abort_pending=0, overflow=0, frame_valid=0, frame_data=0, out_valid=0, out_data=0, done=0, busy=0.
REQ-037 Reset asserted mid-sweep takes effect immediately; no done pulse; next sweep starts only after a new start_trig.

Structure
REQ-038 Package spi_seq_pkg holds the state enum, CONVERT opcode 2'b00, DUMMY_CMD 16'hE800, and the PIPE_DEPTH default.
REQ-039 Single module, no sub-modules; command encoding is inline.

Verification
REQ-040 last_ch=31, loop_en=0, start pulse, engine with a 150-cycle frame time -> 34 frames, 32 out_valid with ch 0..31 in order, one done, busy low afterwards.
REQ-041 last_ch=5, loop_en=1 -> 8 frames per sweep, sweep_cnt field 0,1,2 on successive sweeps, done pulse each sweep.
REQ-042 out_ready held low during the result for ch=3 -> that word is missing, overflow=1 and stays high, remaining results correct.
REQ-043 abort in WAIT_RX at f=4 -> rx completes, result ch=2 emitted, IDLE, no done pulse; then start_trig -> sweep_cnt is unchanged and the sweep runs normally.
REQ-044 Simultaneous start and abort in IDLE -> stays IDLE; start while busy -> no effect on frame count.
REQ-045 reset pulsed mid-sweep (f=10) -> all outputs zero, and no frame_valid until the next start_trig.
